// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared types and encodings for the multi-cycle controller
//
// Contents:
//   XLEN_OP       opcode field width (7, fixed by RV32I)
//   state_t       main FSM states FETCH..JAL plus HALT
//   OP_*          decoded opcode constants
//   alu_op_t      ALUOp encoding between the FSM and the ALU decoder
//   ALU_*         ALUControl encodings
//   IMM_*         ImmSrc encodings

package mc_pkg;

   localparam int XLEN_OP = 7;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      BEQ      = 4'd9,
      JAL      = 4'd10,
      HALT     = 4'd11
   } state_t;

   localparam logic [XLEN_OP-1:0] OP_LW  = 7'b0000011;
   localparam logic [XLEN_OP-1:0] OP_SW  = 7'b0100011;
   localparam logic [XLEN_OP-1:0] OP_R   = 7'b0110011;
   localparam logic [XLEN_OP-1:0] OP_I   = 7'b0010011;
   localparam logic [XLEN_OP-1:0] OP_JAL = 7'b1101111;
   localparam logic [XLEN_OP-1:0] OP_BEQ = 7'b1100011;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } alu_op_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/mc_alu_decoder.sv
// rtl/mc_alu_decoder.sv - combinational ALUOp/funct to ALUControl decoder
//
// Ports:
//   alu_op       in  2  operation class requested by the main FSM
//   funct3       in  3  instruction[14:12]
//   funct7b5     in  1  instruction[30]
//   op5          in  1  instruction[5]; separates R-type (sub possible) from I-type
//   alu_control  out 3  ALU operation select

module mc_alu_decoder
   import mc_pkg::*;
(
   input  alu_op_t    alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       op5,
   output logic [2:0] alu_control
);

   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_ADD: alu_control = ALU_ADD;
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // addi never subtracts: instruction[30] is an immediate bit there
               3'b000:  alu_control = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - RV32I multi-cycle control unit (Moore FSM + decoders)
//
// Optional build macro: MC_ILLEGAL_HALT_EN (unrecognised opcode parks in HALT).
//
// Ports:
//   clk         in  1  rising-edge clock
//   reset       in  1  asynchronous active-high, forces FETCH
//   op          in  7  instruction[6:0]
//   funct3      in  3  instruction[14:12]
//   funct7b5    in  1  instruction[30]
//   Zero        in  1  ALU zero flag
//   PCWrite     out 1  PC enable (PCUpdate | Branch & Zero)
//   AdrSrc      out 1  memory address: 0 PC, 1 ALUOut
//   MemWrite    out 1  memory write strobe
//   IRWrite     out 1  instruction / OldPC enable
//   RegWrite    out 1  register file write enable
//   ResultSrc   out 2  00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA     out 2  00 PC, 01 OldPC, 10 rs1
//   ALUSrcB     out 2  00 rs2, 01 ImmExt, 10 constant 4
//   ImmSrc      out 2  00 I, 01 S, 10 B, 11 J
//   ALUControl  out 3  ALU operation
//   halted      out 1  high while in HALT

module multicycle_controller
   import mc_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [XLEN_OP-1:0] op,
   input  logic [2:0]         funct3,
   input  logic               funct7b5,
   input  logic               Zero,
   output logic               PCWrite,
   output logic               AdrSrc,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               RegWrite,
   output logic [1:0]         ResultSrc,
   output logic [1:0]         ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ImmSrc,
   output logic [2:0]         ALUControl,
   output logic               halted
);

   state_t  state;
   state_t  next_state;
   alu_op_t alu_op;
   logic    branch;
   logic    pc_update;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= FETCH;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      alu_op     = ALUOP_ADD;
      branch     = 1'b0;
      pc_update  = 1'b0;
      case (state)
         FETCH: begin
            IRWrite    = 1'b1;
            ALUSrcB    = 2'b10;
            ResultSrc  = 2'b10;
            pc_update  = 1'b1;
            next_state = DECODE;
         end
         DECODE: begin
            // speculative branch target OldPC + ImmExt, parked in ALUOut
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            case (op)
               OP_LW, OP_SW: next_state = MEMADR;
               OP_R:         next_state = EXECUTER;
               OP_I:         next_state = EXECUTEI;
               OP_JAL:       next_state = JAL;
               OP_BEQ:       next_state = BEQ;
`ifdef MC_ILLEGAL_HALT_EN
               default:      next_state = HALT;
`else
               default:      next_state = FETCH;
`endif
            endcase
         end
         MEMADR: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            next_state = (op == OP_LW) ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            AdrSrc     = 1'b1;
            next_state = MEMWB;
         end
         MEMWB: begin
            ResultSrc  = 2'b01;
            RegWrite   = 1'b1;
            next_state = FETCH;
         end
         MEMWRITE: begin
            AdrSrc     = 1'b1;
            MemWrite   = 1'b1;
            next_state = FETCH;
         end
         EXECUTER: begin
            ALUSrcA    = 2'b10;
            alu_op     = ALUOP_FUNCT;
            next_state = ALUWB;
         end
         EXECUTEI: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            alu_op     = ALUOP_FUNCT;
            next_state = ALUWB;
         end
         ALUWB: begin
            RegWrite   = 1'b1;
            next_state = FETCH;
         end
         BEQ: begin
            ALUSrcA    = 2'b10;
            alu_op     = ALUOP_SUB;
            branch     = 1'b1;
            next_state = FETCH;
         end
         JAL: begin
            // PC takes the target from ALUOut while the ALU forms OldPC + 4 for rd
            ALUSrcA    = 2'b01;
            ALUSrcB    = 2'b10;
            pc_update  = 1'b1;
            next_state = ALUWB;
         end
         HALT: begin
            next_state = HALT;
         end
         default: begin
            next_state = FETCH;
         end
      endcase
   end

   assign PCWrite = pc_update | (branch & Zero);

   always_comb begin
      ImmSrc = IMM_I;
      case (op)
         OP_LW, OP_I: ImmSrc = IMM_I;
         OP_SW:       ImmSrc = IMM_S;
         OP_BEQ:      ImmSrc = IMM_B;
         OP_JAL:      ImmSrc = IMM_J;
         default:     ImmSrc = IMM_I;
      endcase
   end

   mc_alu_decoder u_alu_decoder (
      .alu_op      (alu_op),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .op5         (op[5]),
      .alu_control (ALUControl)
   );

`ifdef MC_ILLEGAL_HALT_EN
   assign halted = (state == HALT);
`else
   assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller
//
// Expected vectors are packed as
// {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, halted}

module tb_multicycle_controller;

   logic       clk;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       Zero;
   logic       PCWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ImmSrc;
   logic [2:0] ALUControl;
   logic       halted;

   int total = 0;
   int bad   = 0;

   multicycle_controller dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .Zero       (Zero),
      .PCWrite    (PCWrite),
      .AdrSrc     (AdrSrc),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .RegWrite   (RegWrite),
      .ResultSrc  (ResultSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ImmSrc     (ImmSrc),
      .ALUControl (ALUControl),
      .halted     (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [16:0] exp);
      logic [16:0] obs;
      obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ImmSrc, ALUControl, halted};
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag, input logic [16:0] exp);
      @(negedge clk);
      chk(tag, exp);
   endtask

   initial begin
      reset    = 1'b1;
      op       = 7'b0100011;
      funct3   = 3'b000;
      funct7b5 = 1'b0;
      Zero     = 1'b0;
      #22;
      reset = 1'b0;
      #1;
      chk("reset_fetch", 17'b1_0_0_1_0_10_00_10_01_000_0);

      // sw: FETCH DECODE MEMADR MEMWRITE FETCH
      step("sw_decode",   17'b0_0_0_0_0_00_01_01_01_000_0);
      step("sw_memadr",   17'b0_0_0_0_0_00_10_01_01_000_0);
      step("sw_memwrite", 17'b0_1_1_0_0_00_00_00_01_000_0);
      step("sw_fetch",    17'b1_0_0_1_0_10_00_10_01_000_0);

      // lw: 5 states
      op = 7'b0000011;
      step("lw_decode",  17'b0_0_0_0_0_00_01_01_00_000_0);
      step("lw_memadr",  17'b0_0_0_0_0_00_10_01_00_000_0);
      step("lw_memread", 17'b0_1_0_0_0_00_00_00_00_000_0);
      step("lw_memwb",   17'b0_0_0_0_1_01_00_00_00_000_0);
      step("lw_fetch",   17'b1_0_0_1_0_10_00_10_00_000_0);

      // R-type sub
      op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
      step("sub_decode",   17'b0_0_0_0_0_00_01_01_00_000_0);
      step("sub_executer", 17'b0_0_0_0_0_00_10_00_00_001_0);
      step("sub_aluwb",    17'b0_0_0_0_1_00_00_00_00_000_0);
      step("sub_fetch",    17'b1_0_0_1_0_10_00_10_00_000_0);

      // R-type add
      funct7b5 = 1'b0;
      step("add_decode",   17'b0_0_0_0_0_00_01_01_00_000_0);
      step("add_executer", 17'b0_0_0_0_0_00_10_00_00_000_0);
      step("add_aluwb",    17'b0_0_0_0_1_00_00_00_00_000_0);
      step("add_fetch",    17'b1_0_0_1_0_10_00_10_00_000_0);

      // R-type slt
      funct3 = 3'b010;
      step("slt_decode",   17'b0_0_0_0_0_00_01_01_00_000_0);
      step("slt_executer", 17'b0_0_0_0_0_00_10_00_00_101_0);
      step("slt_aluwb",    17'b0_0_0_0_1_00_00_00_00_000_0);
      step("slt_fetch",    17'b1_0_0_1_0_10_00_10_00_000_0);

      // addi with instruction[30] set must still add
      op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
      step("addi_decode",   17'b0_0_0_0_0_00_01_01_00_000_0);
      step("addi_executei", 17'b0_0_0_0_0_00_10_01_00_000_0);
      step("addi_aluwb",    17'b0_0_0_0_1_00_00_00_00_000_0);
      step("addi_fetch",    17'b1_0_0_1_0_10_00_10_00_000_0);

      // ori / andi
      funct3 = 3'b110; funct7b5 = 1'b0;
      step("ori_decode",   17'b0_0_0_0_0_00_01_01_00_000_0);
      step("ori_executei", 17'b0_0_0_0_0_00_10_01_00_011_0);
      step("ori_aluwb",    17'b0_0_0_0_1_00_00_00_00_000_0);
      funct3 = 3'b111;
      step("andi_fetch",    17'b1_0_0_1_0_10_00_10_00_000_0);
      step("andi_decode",   17'b0_0_0_0_0_00_01_01_00_000_0);
      step("andi_executei", 17'b0_0_0_0_0_00_10_01_00_010_0);
      step("andi_aluwb",    17'b0_0_0_0_1_00_00_00_00_000_0);
      step("andi_fetch",    17'b1_0_0_1_0_10_00_10_00_000_0);

      // beq taken; Zero in DECODE must not write PC
      op = 7'b1100011; funct3 = 3'b000; Zero = 1'b1;
      step("beq_decode_zero", 17'b0_0_0_0_0_00_01_01_10_000_0);
      step("beq_taken",       17'b1_0_0_0_0_00_10_00_10_001_0);
      Zero = 1'b0;
      #1;
      chk("beq_zero_drop",    17'b0_0_0_0_0_00_10_00_10_001_0);
      step("beq_fetch",       17'b1_0_0_1_0_10_00_10_10_000_0);

      // beq not taken
      step("beqn_decode", 17'b0_0_0_0_0_00_01_01_10_000_0);
      step("beqn_beq",    17'b0_0_0_0_0_00_10_00_10_001_0);
      step("beqn_fetch",  17'b1_0_0_1_0_10_00_10_10_000_0);

      // jal
      op = 7'b1101111;
      step("jal_decode", 17'b0_0_0_0_0_00_01_01_11_000_0);
      step("jal_jal",    17'b1_0_0_0_0_00_01_10_11_000_0);
      step("jal_aluwb",  17'b0_0_0_0_1_00_00_00_11_000_0);
      step("jal_fetch",  17'b1_0_0_1_0_10_00_10_11_000_0);

      // unrecognised opcode
      op = 7'b1111111;
      step("ill_decode", 17'b0_0_0_0_0_00_01_01_00_000_0);
`ifdef MC_ILLEGAL_HALT_EN
      step("ill_halt0", 17'b0_0_0_0_0_00_00_00_00_000_1);
      step("ill_halt1", 17'b0_0_0_0_0_00_00_00_00_000_1);
      step("ill_halt2", 17'b0_0_0_0_0_00_00_00_00_000_1);
      #2;
      reset = 1'b1;
      #1;
      chk("ill_reset", 17'b1_0_0_1_0_10_00_10_00_000_0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("ill_after_reset", 17'b1_0_0_1_0_10_00_10_00_000_0);
`else
      step("ill_fetch", 17'b1_0_0_1_0_10_00_10_00_000_0);
`endif

      // reset asserted mid-MEMADR of a store
      op = 7'b0100011;
      step("rst_sw_decode", 17'b0_0_0_0_0_00_01_01_01_000_0);
      step("rst_sw_memadr", 17'b0_0_0_0_0_00_10_01_01_000_0);
      #2;
      reset = 1'b1;
      #1;
      chk("rst_async_fetch", 17'b1_0_0_1_0_10_00_10_01_000_0);
      step("rst_held_fetch", 17'b1_0_0_1_0_10_00_10_01_000_0);
      #2;
      reset = 1'b0;
      op = 7'b0000011;
      step("rst_lw_decode", 17'b0_0_0_0_0_00_01_01_00_000_0);
      step("rst_lw_memadr", 17'b0_0_0_0_0_00_10_01_00_000_0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
